// File: rtl/handshake_pkg.sv
// handshake_pkg
// Shared types and helpers for the SPI message receiver.
//   hs_state_t : receiver FSM states
//   hs_err_t   : error code reported on err_code
//   clog2_min1 : counter width helper that never returns zero bits
package handshake_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RECEIVE,
    HOLD,
    RELEASE,
    ERROR
  } hs_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_ABORT,
    ERR_OVERRUN
  } hs_err_t;

  // Width needed to count 0..v-1, at least one bit so a disabled counter stays legal.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/handshake_msg_rx_sync_ff.sv
// sync_ff
// Generic multi-flop synchroniser for a single asynchronous pin.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronised output, STAGES clock edges behind d
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_msg_rx.sv
// handshake_msg_rx
// Four-phase master/slave handshake that collects a fixed-length message
// from the SPI receive shifter and holds it for the downstream consumer.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   master_ready : asynchronous master readiness line
//   rx_valid     : one-cycle strobe, word present on rx_data
//   rx_data      : received word
//   consume      : one-cycle strobe, downstream took the held message
//   slave_ready  : ready to receive (ARMED or RECEIVE)
//   msg_valid    : complete message held on msg_data (HOLD)
//   msg_data     : word i at [i*DATA_W +: DATA_W], word 0 received first
//   word_count   : words captured in the current message
//   busy         : state is not IDLE
//   err_code     : 00 none, 01 timeout, 10 abort, 11 overrun
module handshake_msg_rx
  import handshake_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MSG_LEN     = 4,
  parameter int TIMEOUT     = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          master_ready,
  input  logic                          rx_valid,
  input  logic [DATA_W-1:0]             rx_data,
  input  logic                          consume,
  output logic                          slave_ready,
  output logic                          msg_valid,
  output logic [MSG_LEN*DATA_W-1:0]     msg_data,
  output logic [$clog2(MSG_LEN+1)-1:0]  word_count,
  output logic                          busy,
  output logic [1:0]                    err_code
);

  localparam int CW = $clog2(MSG_LEN + 1);
  localparam int TW = clog2_min1(TIMEOUT);
  localparam logic [CW-1:0] LAST_WORD = CW'(MSG_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic                      mr_s;
  hs_state_t                 state_q, state_d;
  logic [CW-1:0]             word_count_q, word_count_d;
  logic [MSG_LEN*DATA_W-1:0] msg_data_q, msg_data_d;
  hs_err_t                   err_q, err_d;
  logic [TW-1:0]             tmo_q, tmo_d;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_mr_sync (
    .clk (clk),
    .rst (rst),
    .d   (master_ready),
    .q   (mr_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      msg_data_q   <= '0;
      err_q        <= ERR_NONE;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      msg_data_q   <= msg_data_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    msg_data_d   = msg_data_q;
    err_d        = err_q;
    tmo_d        = tmo_q;

    case (state_q)
      IDLE: begin
        if (mr_s) begin
          state_d      = ARMED;
          word_count_d = '0;
          tmo_d        = '0;
          err_d        = ERR_NONE;
        end
      end

      ARMED, RECEIVE: begin
        // A received word wins over abort and timeout, even on the cycle the master drops.
        if (rx_valid) begin
          for (int i = 0; i < MSG_LEN; i++) begin
            if (word_count_q == CW'(i)) begin
              msg_data_d[i*DATA_W +: DATA_W] = rx_data;
            end
          end
          word_count_d = word_count_q + 1'b1;
          tmo_d        = '0;
          if (word_count_q == LAST_WORD) begin
            state_d = HOLD;
          end else if (!mr_s) begin
            state_d = ERROR;
            err_d   = ERR_ABORT;
          end else begin
            state_d = RECEIVE;
          end
        end else if (!mr_s) begin
          // Dropping before any word is a clean withdrawal, not an abort.
          if (state_q == ARMED) begin
            state_d = IDLE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_ABORT;
          end
        end else if ((TIMEOUT > 0) && (tmo_q == TMO_LAST)) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      HOLD: begin
        if (rx_valid) begin
          err_d = ERR_OVERRUN;
        end
        if (consume) begin
          state_d = mr_s ? RELEASE : IDLE;
        end
      end

      RELEASE: begin
        if (rx_valid) begin
          err_d = ERR_OVERRUN;
        end
        if (!mr_s) begin
          state_d = IDLE;
        end
      end

      ERROR: begin
        if (!mr_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    slave_ready = (state_q == ARMED) || (state_q == RECEIVE);
    msg_valid   = (state_q == HOLD);
    busy        = (state_q != IDLE);
  end

  assign msg_data   = msg_data_q;
  assign word_count = word_count_q;
  assign err_code   = err_q;

endmodule

// File: doc/handshake_msg_rx.md
# handshake_msg_rx

Parametrised successor to the single-bit SPI slave handshake. It synchronises the master's `master_ready` line and drives `slave_ready` under a full four-phase protocol. It also collects a fixed-length message of `MSG_LEN` words from the SPI receive shifter, then holds it for the downstream consumer. Per-word timeout, abort and overrun errors are detected and reported. The block sits between the SPI shift register (`rx_valid`/`rx_data`) and the FPGA-side message logic.

## Interface
- `DATA_W`, 8: bits per received word.
- `MSG_LEN`, 4: words per message, ≥1.
- `TIMEOUT`, 1024: max idle cycles between words while receiving; 0 disables the timeout.
- `SYNC_STAGES`, 2: flops in the `master_ready` synchroniser, ≥2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `master_ready` in 1: asynchronous master-readiness line.
- `rx_valid` in 1: one-cycle strobe, a word is present on `rx_data` (already in `clk` domain).
- `rx_data` in DATA_W: received word.
- `consume` in 1: one-cycle strobe, downstream has taken the message.
- `slave_ready` out 1: ready to receive.
- `msg_valid` out 1: complete message held on `msg_data`.
- `msg_data` out MSG_LEN*DATA_W: word i at bits [i*DATA_W +: DATA_W], word 0 = first received.
- `word_count` out $clog2(MSG_LEN+1): words captured in the current message.
- `busy` out 1: state ≠ IDLE.
- `err_code` out 2: 00 none, 01 timeout, 10 abort, 11 overrun.

## Operation
- `master_ready` passes through SYNC_STAGES flops (reset 0), giving `mr_s`. All decisions use `mr_s`.
- Outputs are Moore decodes of the state register, except `msg_data`, `word_count` and `err_code`, which are registers.
- `slave_ready` = state ∈ {ARMED, RECEIVE}. `msg_valid` = state == HOLD.

State transitions:
- **IDLE:**
  - `mr_s`=1 → ARMED. Clear `word_count`, the timeout counter and `err_code`.
- **ARMED / RECEIVE:**
  - `rx_valid` has priority over all other events. It writes `rx_data` into slot `word_count`, increments `word_count` and clears the timeout counter.
  - If `word_count` reaches MSG_LEN → HOLD.
  - Otherwise, if `mr_s`=0 → ERROR with `err_code`=10.
  - Otherwise → RECEIVE.
  - Without `rx_valid`: `mr_s`=0 in ARMED → IDLE, no error.
  - Without `rx_valid`: `mr_s`=0 in RECEIVE → ERROR, 10.
  - Timeout counter reaches TIMEOUT-1 with no `rx_valid` → ERROR, `err_code`=01. This fires after TIMEOUT idle cycles and applies in both ARMED and RECEIVE.
- **HOLD:**
  - `msg_data` is frozen.
  - `rx_valid` is ignored, sets `err_code`=11 and stays in HOLD; the message is preserved.
  - `consume` → IDLE if `mr_s`=0, else RELEASE. `consume` together with `rx_valid` does both: leaves HOLD and flags 11.
- **RELEASE:**
  - Wait for `mr_s`=0 → IDLE.
  - `rx_valid` sets 11.
- **ERROR:**
  - `mr_s`=0 → IDLE.
  - `err_code` holds until the next IDLE→ARMED.
  - Partial `msg_data` is retained.

Other rules:
- `consume` outside HOLD is ignored.
- `rx_valid` in IDLE is ignored, no error.
- Reset mid-operation returns immediately to IDLE. All outputs go to 0 and `msg_data` is cleared.

## Timing
- Reset values: state IDLE; `slave_ready`, `msg_valid`, `busy` = 0; `word_count`=0; `err_code`=00; `msg_data`=0.
- `master_ready` high before edge k → `mr_s` high after SYNC_STAGES edges → `slave_ready` high SYNC_STAGES+1 edges after k.
- The last word's `rx_valid` at edge n → `msg_valid` high after edge n; `msg_data` complete in the same cycle.
- `consume` at edge m → `msg_valid` low after m.
- Deassertion of `master_ready` is seen SYNC_STAGES+1 edges later on `slave_ready`.

## Structure
- `handshake_pkg`: `hs_state_t` enum {IDLE, ARMED, RECEIVE, HOLD, RELEASE, ERROR}; `hs_err_t` enum {ERR_NONE, ERR_TIMEOUT, ERR_ABORT, ERR_OVERRUN}.
- Sub-module `sync_ff #(STAGES)`: a generic async-reset synchroniser, reused for other SPI pins.

## Test plan
- **Normal message:** defaults; raise `master_ready`; send 4 `rx_valid` words 0xA1, 0xB2, 0xC3, 0xD4 → `slave_ready` high at 3 cycles, `msg_valid`=1, `msg_data`=0xD4C3B2A1, `word_count`=4, `err_code`=00.
- **Four-phase release:** after `consume` with `master_ready` still high → state RELEASE, `slave_ready`=0; drop `master_ready` → IDLE (`busy`=0) 3 cycles later.
- **Timeout:** TIMEOUT=16; arm, send 1 word, then idle 16 cycles → `err_code`=01, `slave_ready`=0; drop `master_ready` → IDLE; re-arm → `err_code`=00.
- **Abort:** drop `master_ready` after 2 words → `err_code`=10, `word_count`=2. Repeat with the drop coincident with word 4 → HOLD, no error.
- **Overrun:** `rx_valid` 0xFF in HOLD → `err_code`=11, `msg_data` unchanged. `consume` together with `rx_valid` → IDLE, `err_code`=11.
- **Reset:** assert `rst` in RECEIVE after 3 words → all outputs 0 asynchronously; with MSG_LEN=1, a single word goes ARMED→HOLD directly.
